r2sdf_ctrl: RTL and testbench

Sequencing controller for the radix-2 single-delay-feedback FFT pipeline of N `bf_stage` instances. Tracks the global sample phase, gates pipeline advance, drives each stage's butterfly/delay select and twiddle index, and flags the first and subsequent valid outputs in bit-reversed order. Sits between the stream source and the chained butterfly stages; replaces per-stage `start_ip`/`start_op` bookkeeping.

---
 rtl/r2sdf_pkg.sv | 38 +++
 rtl/r2sdf_stage_seq.sv | 33 +++
 rtl/r2sdf_ctrl.sv | 142 ++++++++++++++
 tb/tb_r2sdf_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/r2sdf_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 SDF FFT sequencer.
package r2sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Offset of stage s in the global sample count: each earlier stage
  // contributes its delay span plus one register of butterfly latency.
  function automatic int d_off(input int s, input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < s; k++) begin
      acc = acc + (1 << (n - 1 - k)) + 1;
    end
    return acc;
  endfunction

  // Cycles from the first input sample to the first output bin.
  function automatic int lat(input int n);
    return (1 << n) - 1 + n;
  endfunction

  // Reverse the low n bits of v; bits at and above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        r[4'(i)] = v[4'(n - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/r2sdf_stage_seq.sv
// Per-stage decode of butterfly/delay select and twiddle index from the
// global sample count t, shifted by this stage's pipeline offset.
module r2sdf_stage_seq
  import r2sdf_pkg::*;
#(
  parameter int N = 3,
  parameter int S = 0
) (
  input  logic [N+1:0] t,
  output logic         bf_sel,
  output logic [N-2:0] tw
);

  localparam int TW = N + 2;
  localparam logic [N+1:0] DOFF     = TW'(d_off(S, N));
  // Local-count bits below this stage's select bit form the twiddle step.
  localparam logic [N-1:0] LOW_MASK = N'((1 << (N - 1 - S)) - 1);

  logic [N-1:0] c;
  logic         active;
  logic [N-2:0] tw_raw;

  // Local count, select bit and twiddle field; everything is zero until
  // the first sample has reached this stage.
  always_comb begin
    c      = N'(t - DOFF);
    active = (t >= DOFF);
    bf_sel = active & c[N-1-S];
    tw_raw = (N-1)'((c & LOW_MASK) << S);
    tw     = (active && !bf_sel) ? tw_raw : '0;
  end

endmodule

// File: rtl/r2sdf_ctrl.sv
// Sequencing controller for an N-stage radix-2 SDF FFT pipeline: tracks
// the global sample count, gates pipeline advance, and decodes per-stage
// selects, twiddle indices and bit-reversed output bin indices.
module r2sdf_ctrl
  import r2sdf_pkg::*;
#(
  parameter int N   = 3,
  parameter int TWW = N - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic               flush,
  output logic               ce,
  output logic [N-1:0]       bf_sel,
  output logic [N*TWW-1:0]   tw_addr,
  output logic               out_valid,
  output logic               out_sof,
  output logic [N-1:0]       out_idx,
  output logic               busy,
  output logic               err
);

  localparam int TW    = N + 2;
  localparam int FRAME = 1 << N;
  localparam logic [TW-1:0] LAT_T   = TW'(lat(N));
  localparam logic [TW-1:0] FRAME_T = TW'(FRAME);
  // Once t reaches the steady-state window it cycles within
  // [LAT, LAT+FRAME-1]: phase and every "t >= offset" test stay correct.
  localparam logic [TW-1:0] TMAX_T  = TW'(lat(N) + FRAME - 1);

  state_t        state, state_nx;
  logic [TW-1:0] t, t_nx, t_inc;
  logic [TW-1:0] drn, drn_nx;
  logic [TW-1:0] rel;
  logic [N-1:0]  p, p_nx;
  logic          err_nx;
  logic          ce_raw;

  // Next-state, counter advance, drain length and framing-error detection.
  always_comb begin
    state_nx = state;
    t_nx     = t;
    drn_nx   = drn;
    err_nx   = err;
    ce_raw   = 1'b0;
    p        = t[N-1:0];
    t_inc    = (t == TMAX_T) ? LAT_T : t + TW'(1);
    case (state)
      IDLE: begin
        if (in_valid && in_sof) begin
          ce_raw   = 1'b1;
          t_nx     = t_inc;
          state_nx = RUN;
        end else begin
          t_nx = '0;
        end
      end
      RUN: begin
        ce_raw = in_valid;
        if (in_valid) begin
          t_nx = t_inc;
          if (in_sof && (p != '0)) begin
            err_nx = 1'b1;
          end else if (!in_sof && (p == '0) && (t != '0)) begin
            err_nx = 1'b1;
          end else begin
            err_nx = err;
          end
        end else begin
          t_nx = t;
        end
        p_nx = t_nx[N-1:0];
        if (flush) begin
          state_nx = DRAIN;
          // Pad out the partial frame, then wait for its last bin.
          drn_nx   = (p_nx == '0) ? LAT_T : FRAME_T - TW'(p_nx) + LAT_T;
        end else begin
          drn_nx = drn;
        end
      end
      DRAIN: begin
        ce_raw = 1'b1;
        t_nx   = t_inc;
        drn_nx = drn - TW'(1);
        if (in_valid || in_sof) begin
          err_nx = 1'b1;
        end else begin
          err_nx = err;
        end
        if (drn == TW'(1)) begin
          state_nx = IDLE;
          t_nx     = '0;
          drn_nx   = '0;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
        drn_nx   = '0;
      end
    endcase
    p_nx = t_nx[N-1:0];
  end

  // State, sample count, drain countdown and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      drn   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      drn   <= drn_nx;
      err   <= err_nx;
    end
  end

  // Output decode from the registered state and count.
  always_comb begin
    ce        = ce_raw & ~rst;
    busy      = (state != IDLE);
    out_valid = busy && (t >= LAT_T);
    rel       = t - LAT_T;
    out_idx   = out_valid ? N'(bitrev(16'(rel), N)) : '0;
    out_sof   = out_valid && (out_idx == '0);
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    r2sdf_stage_seq #(.N(N), .S(s)) u_seq (
      .t      (t),
      .bf_sel (bf_sel[s]),
      .tw     (tw_addr[s*TWW +: TWW])
    );
  end

endmodule

// File: tb/tb_r2sdf_ctrl.sv
// Directed self-checking bench for r2sdf_ctrl with N=3.
module tb_r2sdf_ctrl;

  localparam int N   = 3;
  localparam int TWW = N - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sof, flush;
  logic             ce, out_valid, out_sof, busy, err;
  logic [N-1:0]     bf_sel, out_idx;
  logic [N*TWW-1:0] tw_addr;

  int n_pass  = 0;
  int n_total = 0;
  int nce;
  int first_valid;
  logic [N-1:0]     bf_log [64];
  logic [N*TWW-1:0] tw_log [64];
  logic [N-1:0]     idx_q  [$];
  int               sof_q  [$];
  int               exp_idx [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  r2sdf_ctrl #(.N(N), .TWW(TWW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .flush(flush),
    .ce(ce), .bf_sel(bf_sel), .tw_addr(tw_addr), .out_valid(out_valid),
    .out_sof(out_sof), .out_idx(out_idx), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    nce = 0;
    first_valid = -1;
    idx_q.delete();
    sof_q.delete();
  endtask

  // Drive inputs for the current cycle, let them settle, log ce cycles.
  task automatic set_in(input logic v, input logic s, input logic f);
    in_valid = v;
    in_sof   = s;
    flush    = f;
    #2;
    if (ce && nce < 64) begin
      bf_log[nce] = bf_sel;
      tw_log[nce] = tw_addr;
      if (out_valid) begin
        idx_q.push_back(out_idx);
        if (first_valid < 0) first_valid = nce;
      end
      if (out_sof) sof_q.push_back(nce);
      nce++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic f);
    set_in(v, s, f);
    tick();
  endtask

  task automatic drain_wait(input string tag);
    int i;
    i = 0;
    while (busy && i < 60) begin
      drive(1'b0, 1'b0, 1'b0);
      i++;
    end
    chk({tag, "_drain_done"}, busy, 0);
  endtask

  task automatic check_seq(input string tag, input int nframes);
    chk({tag, "_nbins"}, idx_q.size(), 8 * nframes);
    for (int j = 0; j < idx_q.size() && j < 8 * nframes; j++) begin
      chk({tag, "_idx"}, idx_q[j], exp_idx[j % 8]);
    end
  endtask

  initial begin
    int bad0, bad2;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; flush = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", ce, 0);
    chk("rst_bf_sel", bf_sel, 0);
    chk("rst_tw", tw_addr, 0);
    chk("rst_out", {out_valid, out_sof, out_idx}, 0);
    chk("rst_busy_err", {busy, err}, 0);
    rst = 1'b0;

    // One full frame, flush with the last sample.
    clear_log();
    for (int k = 0; k < 8; k++) drive(1'b1, k == 0, k == 7);
    drain_wait("t1");
    chk("t1_nce", nce, 18);
    chk("t1_first_valid", first_valid, 10);
    check_seq("t1", 1);
    chk("t1_nsof", sof_q.size(), 1);
    if (sof_q.size() > 0) chk("t1_sof_pos", sof_q[0], 10);
    chk("t1_bf_t1", bf_log[1], 3'b000);
    chk("t1_tw_t1", tw_log[1], 6'd1);
    chk("t1_bf_t5", bf_log[5], 3'b001);
    chk("t1_tw_t6", tw_log[6], 6'd8);
    chk("t1_bf_t8", bf_log[8], 3'b010);
    chk("t1_bf_t9", bf_log[9], 3'b100);
    chk("t1_tw_t9", tw_log[9], 6'd1);
    chk("t1_err", err, 0);

    // Same frame with a stall after every sample.
    clear_log();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, k == 7);
      if (k < 7) begin
        set_in(1'b0, 1'b0, 1'b0);
        if (k == 3) chk("t2_stall_ce", ce, 0);
        if (k == 5) begin
          chk("t2_hold_bf_t6", bf_sel, 3'b001);
          chk("t2_hold_tw_t6", tw_addr, 6'd8);
        end
        if (k == 6) begin
          chk("t2_hold_bf_t7", bf_sel, 3'b011);
          chk("t2_hold_tw_t7", tw_addr, 6'd0);
        end
        tick();
      end
    end
    drain_wait("t2");
    chk("t2_nce", nce, 18);
    chk("t2_first_valid", first_valid, 10);
    check_seq("t2", 1);

    // Two back-to-back frames.
    clear_log();
    for (int k = 0; k < 16; k++) drive(1'b1, (k == 0) || (k == 8), k == 15);
    drain_wait("t3");
    chk("t3_nce", nce, 26);
    chk("t3_first_valid", first_valid, 10);
    check_seq("t3", 2);
    chk("t3_nsof", sof_q.size(), 2);
    if (sof_q.size() > 1) begin
      chk("t3_sof0", sof_q[0], 10);
      chk("t3_sof1", sof_q[1], 18);
    end
    bad0 = 0;
    bad2 = 0;
    for (int k = 0; k < nce; k++) begin
      if (bf_log[k][0] !== 1'((k >> 2) & 1)) bad0++;
      if (bf_log[k][2] !== ((k >= 8) ? 1'((k - 8) & 1) : 1'b0)) bad2++;
    end
    chk("t3_bf0_toggle", bad0, 0);
    chk("t3_bf2_toggle", bad2, 0);
    chk("t3_err", err, 0);

    // Misplaced in_sof at phase 3.
    clear_log();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, (k == 0) || (k == 3), k == 7);
      if (k == 3) chk("t4_err_before", err, 0);
      if (k == 4) chk("t4_err_set", err, 1);
      tick();
    end
    drain_wait("t4");
    chk("t4_err_sticky", err, 1);
    check_seq("t4", 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t4_err_cleared", err, 0);

    // Early flush after five samples.
    clear_log();
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, k == 4);
    drain_wait("t5");
    chk("t5_nce", nce, 18);
    check_seq("t5", 1);

    // Reset in the middle of RUN at t=7, then restart.
    clear_log();
    for (int k = 0; k < 7; k++) drive(1'b1, (k == 0) || (k == 2), 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    chk("t6_err_pre_rst", err, 1);
    chk("t6_bf_t7", bf_sel, 3'b011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    chk("t6_ce", ce, 0);
    chk("t6_bf_sel", bf_sel, 0);
    chk("t6_tw", tw_addr, 0);
    chk("t6_out", {out_valid, out_sof, out_idx}, 0);
    chk("t6_busy_err", {busy, err}, 0);
    tick();
    set_in(1'b1, 1'b1, 1'b0);
    chk("t6_restart_ce", ce, 1);
    chk("t6_restart_busy", busy, 0);
    tick();
    set_in(1'b1, 1'b0, 1'b0);
    chk("t6_run_busy", busy, 1);
    chk("t6_run_tw_t1", tw_addr, 6'd1);
    chk("t6_run_bf_t1", bf_sel, 3'b000);
    tick();
    set_in(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
